// File: rtl/sr_accel_arbiter_pkg.sv
// rtl/sr_accel_arbiter_pkg.sv - shared state encoding and default parameters for the accelerator arbiter
package sr_accel_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_RES_W     = 16;
    localparam int DEF_START_TMO = 4;
    localparam int DEF_BUSY_TMO  = 255;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/sr_rr_arb2.sv
// rtl/sr_rr_arb2.sv - two-port round-robin arbiter returning a one-hot grant
module sr_rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/sr_accel_arbiter.sv
// rtl/sr_accel_arbiter.sv - shares one multi-cycle accelerator between two requesters with watchdog recovery
module sr_accel_arbiter
    import sr_accel_arbiter_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RES_W     = DEF_RES_W,
    parameter int START_TMO = DEF_START_TMO,
    parameter int BUSY_TMO  = DEF_BUSY_TMO,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    output logic [RES_W-1:0]  rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    output logic [RES_W-1:0]  rsp1_data,
    output logic              rsp1_err,
    output logic              acc_rst,
    output logic              acc_start,
    output logic [DATA_W-1:0] acc_a,
    output logic [DATA_W-1:0] acc_b,
    input  logic              acc_busy,
    input  logic [RES_W-1:0]  acc_y
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TMO - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TMO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state;
    logic             gnt;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant_oh;

    sr_rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant_oh)
    );

    assign req0_ready = (state == ST_IDLE) && grant_oh[0];
    assign req1_ready = (state == ST_IDLE) && grant_oh[1];
    assign acc_rst    = rst || (state == ST_ABORT);

    // Response registers double as the result register: they are loaded only
    // on the edge that enters RESP/ABORT and cleared on every other edge, so
    // each response is a single-cycle pulse and the idle port reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            acc_start  <= 1'b0;
            acc_a      <= '0;
            acc_b      <= '0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_oh != 2'b00) begin
                        gnt        <= grant_oh[1];
                        last_grant <= grant_oh[1];
                        acc_a      <= grant_oh[1] ? req1_a : req0_a;
                        acc_b      <= grant_oh[1] ? req1_b : req0_b;
                        cnt        <= '0;
                        acc_start  <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A busy that is already high counts as the handshake.
                    if (acc_busy) begin
                        acc_start <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_WAIT;
                    end else if (cnt == START_LAST) begin
                        acc_start <= 1'b0;
                        state     <= ST_ABORT;
                        if (gnt) begin
                            rsp1_valid <= 1'b1;
                            rsp1_err   <= 1'b1;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_err   <= 1'b1;
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!acc_busy) begin
                        state <= ST_RESP;
                        if (gnt) begin
                            rsp1_valid <= 1'b1;
                            rsp1_data  <= acc_y;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_data  <= acc_y;
                        end
                    end else if (cnt == BUSY_LAST) begin
                        state <= ST_ABORT;
                        if (gnt) begin
                            rsp1_valid <= 1'b1;
                            rsp1_err   <= 1'b1;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_err   <= 1'b1;
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP:  state <= ST_IDLE;
                ST_ABORT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
